// File: rtl/axi_time_tx_if.sv
// FIFO read channel bundle shared by the DAC-facing and DMA-FIFO-facing sides
// of axi_time_tx. The master drives the read enable; the slave returns data.
interface axi_time_tx_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  en;
    logic                  valid;
    logic                  underflow;
    logic                  xfer_req;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output en,
        input  valid,
        input  underflow,
        input  data,
        input  xfer_req
    );

    modport slave (
        input  en,
        output valid,
        output underflow,
        output data
    );
endinterface

// File: rtl/axi_time_tx.sv
// Timed transmit gate between a DMA read FIFO and a DAC.
// With time_enable low the FIFO read path is a transparent passthrough.
// With time_enable high, reads are held off until a triggered burst becomes
// active at a programmed timestamp, and the start time is captured.
// Optional build macro AXI_TIME_TX_HOLD_EN: gated read data holds the last
// transferred sample instead of reading as zero.
module axi_time_tx #(
    parameter int COUNT_WIDTH  = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int LENGTH_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    time_enable,
    input  logic [COUNT_WIDTH-1:0]  time_counter,
    input  logic [COUNT_WIDTH-1:0]  time_trigger,
    input  logic                    time_trigger_valid,
    output logic                    time_trigger_ready,
    input  logic [LENGTH_WIDTH-1:0] time_length,
    output logic [COUNT_WIDTH-1:0]  time_capture,
    output logic                    time_capture_valid,
    output logic                    time_running,
    output logic                    time_underrun,

    axi_time_tx_if.slave            fifo_rd_in,
    axi_time_tx_if.master           fifo_rd_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]              state;
    logic [COUNT_WIDTH-1:0]  trigger_reg;
    logic [LENGTH_WIDTH-1:0] length_reg;
    logic [LENGTH_WIDTH-1:0] count;
    logic [LENGTH_WIDTH-1:0] count_next;
    logic                    data_en;
    logic                    xfer;
    logic                    burst_done;
    logic [DATA_WIDTH-1:0]   gated_data;

    assign count_next = count + LENGTH_WIDTH'(1);

    // Gate qualifiers and burst-completion decode
    always_comb begin
        data_en    = ~time_enable | (state == ST_ACTIVE);
        xfer       = fifo_rd_in.en & fifo_rd_out.valid;
        burst_done = 1'b0;
        if (length_reg != '0)
            burst_done = xfer && (count_next == length_reg);
        else
            burst_done = ~fifo_rd_out.xfer_req;
    end

    // Combinational read-path gating between the DAC and the DMA FIFO
    always_comb begin
        time_trigger_ready    = (state == ST_IDLE);
        fifo_rd_out.en        = fifo_rd_in.en & data_en;
        fifo_rd_in.valid      = fifo_rd_out.valid & data_en;
        fifo_rd_in.underflow  = fifo_rd_out.underflow;
        fifo_rd_in.data       = data_en ? fifo_rd_out.data : gated_data;
    end

    // Burst state machine, sample counter and timestamp capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            trigger_reg        <= '0;
            length_reg         <= '0;
            count              <= '0;
            time_capture       <= '0;
            time_capture_valid <= 1'b0;
            time_underrun      <= 1'b0;
            time_running       <= 1'b0;
        end else begin
            time_capture_valid <= 1'b0;
            time_underrun      <= 1'b0;
            time_running       <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (time_enable && time_trigger_valid) begin
                        trigger_reg <= time_trigger;
                        length_reg  <= time_length;
                        state       <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Equality is tested first so a match never also flags underrun
                    if (!time_enable) begin
                        state <= ST_IDLE;
                    end else if (time_counter == trigger_reg) begin
                        time_capture <= time_counter;
                        count        <= '0;
                        state        <= ST_ACTIVE;
                    end else if (time_counter > trigger_reg) begin
                        time_underrun <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (!time_enable) begin
                        state <= ST_IDLE;
                    end else begin
                        if (xfer)
                            count <= count_next;
                        if (burst_done) begin
                            time_capture_valid <= 1'b1;
                            state              <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_TIME_TX_HOLD_EN
    logic [DATA_WIDTH-1:0] hold_data;

    // Remember the last sample that actually moved through the open gate
    always_ff @(posedge clk) begin
        if (reset)
            hold_data <= '0;
        else if (data_en && fifo_rd_in.en && fifo_rd_out.valid)
            hold_data <= fifo_rd_out.data;
    end

    assign gated_data = hold_data;
`else
    assign gated_data = '0;
`endif

endmodule

// File: tb/tb_axi_time_tx.sv
// Self-checking bench for axi_time_tx: randomized bursts checked against a
// timeline model (gate open after the trigger time until the burst ends).
module tb_axi_time_tx;
    localparam int CW = 64;
    localparam int DW = 64;
    localparam int LW = 32;
`ifdef AXI_TIME_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          time_enable;
    logic [CW-1:0] time_counter;
    logic [CW-1:0] time_trigger;
    logic          time_trigger_valid;
    logic          time_trigger_ready;
    logic [LW-1:0] time_length;
    logic [CW-1:0] time_capture;
    logic          time_capture_valid;
    logic          time_running;
    logic          time_underrun;

    axi_time_tx_if #(.DATA_WIDTH(DW)) dac ();
    axi_time_tx_if #(.DATA_WIDTH(DW)) dma ();

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] last_xfer = '0;

    always #5 clk = ~clk;

    axi_time_tx #(.COUNT_WIDTH(CW), .DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) dut (
        .clk                (clk),
        .reset              (reset),
        .time_enable        (time_enable),
        .time_counter       (time_counter),
        .time_trigger       (time_trigger),
        .time_trigger_valid (time_trigger_valid),
        .time_trigger_ready (time_trigger_ready),
        .time_length        (time_length),
        .time_capture       (time_capture),
        .time_capture_valid (time_capture_valid),
        .time_running       (time_running),
        .time_underrun      (time_underrun),
        .fifo_rd_in         (dac),
        .fifo_rd_out        (dma)
    );

    function automatic logic [DW-1:0] idle_data();
        return HOLD ? last_xfer : '0;
    endfunction

    // Advance one clock; track the last sample that went through an open gate.
    task automatic tick(input bit gate);
        if (gate && dac.en && dma.valid) last_xfer = dma.data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        last_xfer = '0;
        @(negedge clk);
        total++; if (time_trigger_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", time_trigger_ready); end
        total++; if (time_running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b exp=0", time_running); end
        total++; if (time_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%0b exp=0", time_underrun); end
        total++; if (time_capture_valid !== 1'b0) begin bad++; $display("FAIL reset_cap_valid got=%0b exp=0", time_capture_valid); end
        total++; if (time_capture !== '0) begin bad++; $display("FAIL reset_capture got=%0h exp=0", time_capture); end
        reset = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_passthrough;
        logic [DW-1:0] d;
        time_enable = 1'b0;
        for (int k = 0; k < 12; k++) begin
            d = (k == 0) ? 64'h11 : (k == 1) ? 64'h22 : {$urandom(), $urandom()};
            dma.data      = d;
            dac.en        = (k < 2) ? 1'b1 : 1'(($urandom_range(1)));
            dma.valid     = (k < 2) ? 1'b1 : 1'(($urandom_range(1)));
            dma.underflow = 1'($urandom_range(1));
            @(negedge clk);
            total++; if (dac.data !== d) begin bad++; $display("FAIL pass_data k=%0d got=%0h exp=%0h", k, dac.data, d); end
            total++; if (dma.en !== dac.en) begin bad++; $display("FAIL pass_out_en k=%0d got=%0b exp=%0b", k, dma.en, dac.en); end
            total++; if (dac.valid !== dma.valid) begin bad++; $display("FAIL pass_valid k=%0d got=%0b exp=%0b", k, dac.valid, dma.valid); end
            total++; if (dac.underflow !== dma.underflow) begin bad++; $display("FAIL pass_underflow k=%0d got=%0b exp=%0b", k, dac.underflow, dma.underflow); end
            total++; if (time_trigger_ready !== 1'b1) begin bad++; $display("FAIL pass_ready k=%0d got=%0b exp=1", k, time_trigger_ready); end
            tick(1'b1);
        end
    endtask

    // Burst model: the gate is open from the cycle after the counter reaches
    // the trigger until the finishing cycle (length-th transfer, or xfer_req
    // low for unbounded bursts). fin is the cycle index of that last cycle.
    task automatic test_burst(input logic [CW-1:0] trig, input int lead, input logic [LW-1:0] len,
                              input bit cont, input int stop_after);
        int  done = 0;
        int  fin  = -1;
        int  limit;
        bit  gate, rdy_exp, run_exp, cv_exp, xf;
        logic [DW-1:0] dexp;
        limit = lead + 4 * int'(len) + stop_after + 20;
        time_enable        = 1'b1;
        time_trigger       = trig;
        time_length        = len;
        time_trigger_valid = 1'b1;
        time_counter       = trig - CW'(lead);
        for (int k = 0; k < limit; k++) begin
            dac.en        = cont ? 1'b1 : ($urandom_range(3) != 0);
            dma.valid     = cont ? 1'b1 : ($urandom_range(3) != 0);
            dma.data      = {$urandom(), $urandom()};
            dma.underflow = 1'($urandom_range(1));
            dma.xfer_req  = (len != '0) || (k < lead + stop_after);
            gate    = (time_counter > trig) && (fin < 0);
            rdy_exp = !(k >= 1 && fin < 0);
            run_exp = (k >= 2) && (fin < 0 || k - 1 <= fin);
            cv_exp  = (fin >= 0) && (k == fin + 1);
            dexp    = gate ? dma.data : idle_data();
            @(negedge clk);
            total++; if (dma.en !== (dac.en & gate)) begin bad++; $display("FAIL burst_out_en k=%0d got=%0b exp=%0b", k, dma.en, dac.en & gate); end
            total++; if (dac.valid !== (dma.valid & gate)) begin bad++; $display("FAIL burst_valid k=%0d got=%0b exp=%0b", k, dac.valid, dma.valid & gate); end
            total++; if (dac.data !== dexp) begin bad++; $display("FAIL burst_data k=%0d got=%0h exp=%0h", k, dac.data, dexp); end
            total++; if (dac.underflow !== dma.underflow) begin bad++; $display("FAIL burst_underflow k=%0d got=%0b exp=%0b", k, dac.underflow, dma.underflow); end
            total++; if (time_trigger_ready !== rdy_exp) begin bad++; $display("FAIL burst_ready k=%0d got=%0b exp=%0b", k, time_trigger_ready, rdy_exp); end
            total++; if (time_running !== run_exp) begin bad++; $display("FAIL burst_running k=%0d got=%0b exp=%0b", k, time_running, run_exp); end
            total++; if (time_capture_valid !== cv_exp) begin bad++; $display("FAIL burst_cap_valid k=%0d got=%0b exp=%0b", k, time_capture_valid, cv_exp); end
            total++; if (time_underrun !== 1'b0) begin bad++; $display("FAIL burst_underrun k=%0d got=%0b exp=0", k, time_underrun); end
            xf = gate && dac.en && dma.valid;
            if (xf) done++;
            if (gate && ((len != '0) ? (xf && done == int'(len)) : !dma.xfer_req)) fin = k;
            tick(gate);
            time_trigger_valid = 1'b0;
            time_counter       = time_counter + 1;
            if (fin >= 0 && k >= fin + 2) break;
        end
        total++; if (fin < 0) begin bad++; $display("FAIL burst_timeout got=unfinished exp=finished len=%0d", len); end
        total++; if (time_capture !== trig) begin bad++; $display("FAIL burst_capture got=%0h exp=%0h", time_capture, trig); end
        if (len != '0) begin
            total++; if (done !== int'(len)) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", done, len); end
        end
    endtask

    task automatic test_late_trigger(input logic [CW-1:0] cnt, input logic [CW-1:0] trig);
        bit ur_exp, rdy_exp, run_exp;
        time_enable        = 1'b1;
        time_counter       = cnt;
        time_trigger       = trig;
        time_length        = 32'd4;
        time_trigger_valid = 1'b1;
        dac.en             = 1'b1;
        dma.valid          = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dma.data = {$urandom(), $urandom()};
            ur_exp  = (k == 2);
            rdy_exp = (k != 1);
            run_exp = (k == 2);
            @(negedge clk);
            total++; if (time_underrun !== ur_exp) begin bad++; $display("FAIL late_underrun k=%0d got=%0b exp=%0b", k, time_underrun, ur_exp); end
            total++; if (time_trigger_ready !== rdy_exp) begin bad++; $display("FAIL late_ready k=%0d got=%0b exp=%0b", k, time_trigger_ready, rdy_exp); end
            total++; if (time_running !== run_exp) begin bad++; $display("FAIL late_running k=%0d got=%0b exp=%0b", k, time_running, run_exp); end
            total++; if (dma.en !== 1'b0) begin bad++; $display("FAIL late_out_en k=%0d got=%0b exp=0", k, dma.en); end
            total++; if (time_capture_valid !== 1'b0) begin bad++; $display("FAIL late_cap_valid k=%0d got=%0b exp=0", k, time_capture_valid); end
            tick(1'b0);
            time_trigger_valid = 1'b0;
        end
    endtask

    task automatic test_abort_enable;
        logic [CW-1:0] trig;
        int m;
        trig = 64'd5000 + CW'($urandom_range(1000));
        m    = $urandom_range(1, 5);
        time_enable        = 1'b1;
        time_trigger       = trig;
        time_length        = 32'd100;
        time_trigger_valid = 1'b1;
        time_counter       = trig - 2;
        dac.en             = 1'b1;
        dma.valid          = 1'b1;
        dma.xfer_req       = 1'b1;
        for (int k = 0; k < 3 + m; k++) begin
            dma.data = {$urandom(), $urandom()};
            tick(k >= 3);
            time_trigger_valid = 1'b0;
            time_counter       = time_counter + 1;
        end
        @(negedge clk);
        total++; if (dma.en !== 1'b1) begin bad++; $display("FAIL abort_active_out_en got=%0b exp=1", dma.en); end
        time_enable = 1'b0;
        tick(1'b1);
        @(negedge clk);
        total++; if (time_trigger_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b exp=1", time_trigger_ready); end
        total++; if (time_capture_valid !== 1'b0) begin bad++; $display("FAIL abort_cap_valid got=%0b exp=0", time_capture_valid); end
        tick(1'b1);
        time_enable = 1'b1;
        @(negedge clk);
        total++; if (time_capture_valid !== 1'b0) begin bad++; $display("FAIL abort_cap_valid2 got=%0b exp=0", time_capture_valid); end
        total++; if (time_running !== 1'b0) begin bad++; $display("FAIL abort_running got=%0b exp=0", time_running); end
        total++; if (dma.en !== 1'b0) begin bad++; $display("FAIL abort_idle_out_en got=%0b exp=0", dma.en); end
        tick(1'b0);
    endtask

    task automatic test_reset_armed;
        time_enable        = 1'b1;
        time_counter       = 64'd10000;
        time_trigger       = 64'd20000;
        time_length        = 32'd3;
        time_trigger_valid = 1'b1;
        dac.en             = 1'b1;
        dma.valid          = 1'b1;
        tick(1'b0);
        time_trigger_valid = 1'b0;
        @(negedge clk);
        total++; if (time_trigger_ready !== 1'b0) begin bad++; $display("FAIL rst_armed_ready_pre got=%0b exp=0", time_trigger_ready); end
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        last_xfer = '0;
        @(negedge clk);
        total++; if (time_trigger_ready !== 1'b1) begin bad++; $display("FAIL rst_armed_ready got=%0b exp=1", time_trigger_ready); end
        total++; if (time_running !== 1'b0) begin bad++; $display("FAIL rst_armed_running got=%0b exp=0", time_running); end
        total++; if (time_capture !== '0) begin bad++; $display("FAIL rst_armed_capture got=%0h exp=0", time_capture); end
        total++; if (time_capture_valid !== 1'b0) begin bad++; $display("FAIL rst_armed_cap_valid got=%0b exp=0", time_capture_valid); end
        total++; if (time_underrun !== 1'b0) begin bad++; $display("FAIL rst_armed_underrun got=%0b exp=0", time_underrun); end
        total++; if (dma.en !== 1'b0) begin bad++; $display("FAIL rst_armed_out_en got=%0b exp=0", dma.en); end
        total++; if (dac.data !== '0) begin bad++; $display("FAIL rst_armed_data got=%0h exp=0", dac.data); end
        reset = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_hold;
        logic [DW-1:0] exp_d;
        time_enable = 1'b0;
        dac.en      = 1'b1;
        dma.valid   = 1'b1;
        dma.data    = 64'hABCD;
        @(negedge clk);
        total++; if (dac.data !== 64'hABCD) begin bad++; $display("FAIL hold_pass got=%0h exp=abcd", dac.data); end
        tick(1'b1);
        time_enable = 1'b1;
        dma.data    = 64'h1234;
        exp_d       = HOLD ? 64'hABCD : 64'h0;
        @(negedge clk);
        total++; if (dac.data !== exp_d) begin bad++; $display("FAIL hold_gated got=%0h exp=%0h", dac.data, exp_d); end
        total++; if (dac.valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%0b exp=0", dac.valid); end
        tick(1'b0);
    endtask

    initial begin
        reset              = 1'b1;
        time_enable        = 1'b0;
        time_counter       = '0;
        time_trigger       = '0;
        time_trigger_valid = 1'b0;
        time_length        = '0;
        dac.en             = 1'b0;
        dac.xfer_req       = 1'b0;
        dma.valid          = 1'b0;
        dma.underflow      = 1'b0;
        dma.xfer_req       = 1'b1;
        dma.data           = '0;

        test_reset();
        test_passthrough();
        test_burst(64'd100, 10, 32'd4, 1'b1, 1);
        test_late_trigger(64'd200, 64'd150);
        test_burst(64'd50, 5, 32'd0, 1'b1, 6);
        for (int i = 0; i < 8; i++) begin
            test_burst(64'd1000 + CW'($urandom_range(100000)), $urandom_range(1, 10),
                       LW'($urandom_range(0, 6)), 1'b0, $urandom_range(1, 8));
        end
        for (int i = 0; i < 2; i++) begin
            logic [CW-1:0] c;
            c = 64'd300 + CW'($urandom_range(1000));
            test_late_trigger(c, c - 1 - CW'($urandom_range(100)));
        end
        test_abort_enable();
        test_reset_armed();
        test_hold();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_time_tx.md
AXI_TIME_TX -- requirements
Module: axi_time_tx

Interface
REQ-001 Parameter COUNT_WIDTH, default 64: width of time counter, trigger and capture buses.
REQ-002 Parameter DATA_WIDTH, default 64: width of the DAC FIFO read data path.
REQ-003 Parameter LENGTH_WIDTH, default 32: width of the burst sample count.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 time_enable  in  1  0 = transparent passthrough; 1 = timed transmit gating.
REQ-007 time_counter  in  COUNT_WIDTH  free-running timebase.
REQ-008 time_trigger / time_trigger_valid  in  COUNT_WIDTH / 1  start timestamp plus qualifier.
REQ-009 time_trigger_ready  out  1  high when a new trigger can be accepted.
REQ-010 time_length  in  LENGTH_WIDTH  samples per burst, sampled at trigger accept; 0 = unbounded.
REQ-011 time_capture / time_capture_valid  out  COUNT_WIDTH / 1  burst start timestamp plus 1-cycle qualifier.
REQ-012 time_running / time_underrun  out  1 / 1  burst pending or active; late-trigger pulse.
REQ-013 fifo_rd_in_en  in  1; fifo_rd_in_valid, fifo_rd_in_underflow  out  1; fifo_rd_in_data  out  DATA_WIDTH: DAC-facing side.
REQ-014 fifo_rd_out_en  out  1; fifo_rd_out_valid, fifo_rd_out_underflow, fifo_rd_out_xfer_req  in  1; fifo_rd_out_data  in  DATA_WIDTH: DMA-FIFO-facing side.

Function
REQ-015 The block SHALL implement the registered states IDLE, ARMED and ACTIVE.
REQ-016 The block SHALL drive time_trigger_ready = (state == IDLE).
REQ-017 In IDLE with time_enable & time_trigger_valid, the block SHALL latch time_trigger and time_length and enter ARMED.
REQ-018 In ARMED with time_counter == trigger, the block SHALL latch time_counter into time_capture, clear the sample count and enter ACTIVE on the next edge.
REQ-019 In ARMED with time_counter > trigger (unsigned), the block SHALL assert time_underrun for exactly one cycle and return to IDLE.
REQ-020 data_en SHALL equal ~time_enable | (state == ACTIVE).
REQ-021 fifo_rd_out_en SHALL equal fifo_rd_in_en & data_en, combinationally.
REQ-022 fifo_rd_in_valid SHALL equal fifo_rd_out_valid & data_en, combinationally.
REQ-023 fifo_rd_in_data SHALL equal fifo_rd_out_data when data_en is 1, otherwise 0.
REQ-024 fifo_rd_in_underflow SHALL equal fifo_rd_out_underflow, combinationally.
REQ-025 In ACTIVE, the block SHALL count each cycle with fifo_rd_in_en & fifo_rd_out_valid, wrapping at LENGTH_WIDTH bits.
REQ-026 With nonzero length, the transfer that brings the count to length SHALL return the state to IDLE; that transfer passes through.
REQ-027 With length 0, ACTIVE SHALL end when fifo_rd_out_xfer_req is 0.
REQ-028 On leaving ACTIVE, the block SHALL register one time_capture_valid pulse; time_capture SHALL hold until the next trigger match.
REQ-029 time_running SHALL be registered as (state != IDLE), i.e. one cycle behind the state.
REQ-030 Deasserting time_enable in ARMED or ACTIVE SHALL force IDLE next edge, with no underrun and no capture pulse.
REQ-031 A trigger match and an underrun SHALL be mutually exclusive; the match takes priority for equality.

Reset
REQ-032 While reset is high, state SHALL be IDLE and the sample count 0.
REQ-033 While reset is high, time_running, time_underrun and time_capture_valid SHALL be 0, and time_capture SHALL be all zeros.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no capture pulse; the gating outputs then follow REQ-020 to REQ-024.

Configuration
REQ-035 With AXI_TIME_TX_HOLD_EN defined, fifo_rd_in_data SHALL hold the last data transferred while data_en is 0; the hold register SHALL reset to 0.
REQ-036 Without AXI_TIME_TX_HOLD_EN, gated data SHALL be 0 per REQ-023, and no hold register SHALL exist.

Verification
REQ-037 Passthrough: time_enable=0, stream 0x11,0x22 -> identical data on fifo_rd_in_data; fifo_rd_out_en mirrors fifo_rd_in_en; time_trigger_ready=1.
REQ-038 Timed burst: enable=1, trigger=100, length=4, counter at 90, continuous reads -> out_en 0 until counter 101; exactly 4 transfers; time_capture=100; one capture_valid pulse; running falls 1 cycle after IDLE.
REQ-039 Late trigger: counter=200, trigger=150 -> single-cycle time_underrun; ready returns high; no data passes.
REQ-040 Unbounded burst: length=0, trigger=50 -> data passes from counter 51 until xfer_req=0, then IDLE plus capture pulse.
REQ-041 Abort cases: time_enable=0 during ACTIVE -> IDLE next cycle, no capture pulse; reset high in ARMED -> all outputs at reset values.
REQ-042 Hold mode: with AXI_TIME_TX_HOLD_EN, last sample 0xABCD then gate closes -> fifo_rd_in_data stays 0xABCD; without the macro -> 0.
